// File: rtl/data_mem_bytes.sv
// Byte-addressed data memory for the SimpleCPU memory stage: byte/half/word
// loads and stores with per-byte enables, extension on loads, 1- or 2-cycle latency.
module data_mem_bytes #(
  parameter int DEPTH_LOG2   = 10,
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  logic [DEPTH_LOG2-1:0] widx;
  logic [1:0]            lane;
  logic                  err_range;
  logic                  err_align;
  logic                  err_rsvd;
  logic                  req_err;
  logic [3:0]            be;
  logic [31:0]           wdata_rep;
  logic                  wr_en;

  assign widx = req_addr[DEPTH_LOG2+1:2];
  assign lane = req_addr[1:0];

  assign err_range = |req_addr[31:DEPTH_LOG2+2];
  assign err_align = ((req_size == SZ_HALF) && req_addr[0]) ||
                     ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
  assign err_rsvd  = (req_size == SZ_RSVD);
  assign req_err   = err_range || err_align || err_rsvd;

  always_comb begin
    be        = 4'b0000;
    wdata_rep = req_wdata;
    case (req_size)
      SZ_BYTE: begin
        be        = 4'b0001 << lane;
        wdata_rep = {4{req_wdata[7:0]}};
      end
      SZ_HALF: begin
        be        = lane[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{req_wdata[15:0]}};
      end
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  // Gating with rst_n keeps a store presented during reset from committing.
  assign wr_en = req_valid && req_we && !req_err && rst_n;

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[widx][8*b +: 8] <= wdata_rep[8*b +: 8];
      end
    end
  end

  logic        valid_q;
  logic        we_q;
  logic        uns_q;
  logic        err_q;
  logic [1:0]  lane_q;
  logic [1:0]  size_q;
  logic [31:0] word_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      lane_q  <= 2'b00;
      size_q  <= 2'b00;
      word_q  <= '0;
    end else begin
      valid_q <= req_valid;
      if (req_valid) begin
        we_q   <= req_we;
        uns_q  <= req_unsigned;
        err_q  <= req_err;
        lane_q <= lane;
        size_q <= req_size;
        word_q <= mem_q[widx];
      end
    end
  end

  logic [31:0] shifted;
  logic [7:0]  sel_b;
  logic [15:0] sel_h;
  logic [31:0] rdata_d;
  logic        err_d;
  logic        valid_d;

  assign shifted = word_q >> {lane_q, 3'b000};
  assign sel_b   = shifted[7:0];
  assign sel_h   = lane_q[1] ? word_q[31:16] : word_q[15:0];

  // Stores, errors and idle cycles all present zero data.
  always_comb begin
    rdata_d = '0;
    if (valid_q && !we_q && !err_q) begin
      case (size_q)
        SZ_BYTE: rdata_d = {{24{~uns_q & sel_b[7]}}, sel_b};
        SZ_HALF: rdata_d = {{16{~uns_q & sel_h[15]}}, sel_h};
        default: rdata_d = word_q;
      endcase
    end
  end

  assign err_d   = valid_q && err_q;
  assign valid_d = valid_q;

  generate
    if (READ_LATENCY == 1) begin : g_lat1
      assign rsp_valid = valid_d;
      assign rsp_rdata = rdata_d;
      assign rsp_err   = err_d;
    end else if (READ_LATENCY == 2) begin : g_lat2
      logic        rsp_valid_q;
      logic        rsp_err_q;
      logic [31:0] rsp_rdata_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= '0;
        end else begin
          rsp_valid_q <= valid_d;
          rsp_err_q   <= err_d;
          rsp_rdata_q <= rdata_d;
        end
      end

      assign rsp_valid = rsp_valid_q;
      assign rsp_rdata = rsp_rdata_q;
      assign rsp_err   = rsp_err_q;
    end else begin : g_bad_latency
      $error("data_mem_bytes: READ_LATENCY must be 1 or 2");
      assign rsp_valid = 1'b0;
      assign rsp_rdata = '0;
      assign rsp_err   = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_data_mem_bytes.sv
// Directed bench for data_mem_bytes: one instance per read latency, same stimulus,
// hand-computed expected responses tracked through a small latency model.
module tb_data_mem_bytes;

  localparam logic [1:0] SB = 2'b00;
  localparam logic [1:0] SH = 2'b01;
  localparam logic [1:0] SW = 2'b10;
  localparam logic [1:0] SR = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;

  logic        v1, er1, v2, er2;
  logic [31:0] r1, r2;

  always #5 clk = ~clk;

  data_mem_bytes #(.DEPTH_LOG2(10), .READ_LATENCY(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(v1), .rsp_rdata(r1), .rsp_err(er1)
  );

  data_mem_bytes #(.DEPTH_LOG2(10), .READ_LATENCY(2)) u_lat2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(v2), .rsp_rdata(r2), .rsp_err(er2)
  );

  typedef struct {
    bit          v;
    bit          we;
    logic [1:0]  size;
    bit          uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    bit          err;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cur_idx = 0;

  // Expected responses one and two cycles after acceptance.
  bit          ev1 = 1'b0, ev2 = 1'b0;
  bit          ee1 = 1'b0, ee2 = 1'b0;
  logic [31:0] ed1 = '0, ed2 = '0;

  function automatic vec_t mk(bit we, logic [1:0] size, bit uns, logic [31:0] addr,
                              logic [31:0] wdata, logic [31:0] exp, bit err);
    vec_t t;
    t.v = 1'b1; t.we = we; t.size = size; t.uns = uns;
    t.addr = addr; t.wdata = wdata; t.exp = exp; t.err = err;
    return t;
  endfunction

  function automatic vec_t idle();
    vec_t t;
    t.v = 1'b0; t.we = 1'b0; t.size = SB; t.uns = 1'b0;
    t.addr = '0; t.wdata = '0; t.exp = '0; t.err = 1'b0;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s [step %0d]: got %08h, want %08h", name, cur_idx, act, exp);
    end
  endtask

  // Called just after a rising edge: drive, check both DUTs mid-cycle, advance the model.
  task automatic step(input vec_t t);
    req_valid    = t.v;
    req_we       = t.we;
    req_size     = t.size;
    req_unsigned = t.uns;
    req_addr     = t.addr;
    req_wdata    = t.wdata;
    @(negedge clk);
    chk("lat1_valid", {31'b0, v1}, {31'b0, ev1});
    chk("lat1_rdata", r1, ed1);
    chk("lat1_err", {31'b0, er1}, {31'b0, ee1});
    chk("lat2_valid", {31'b0, v2}, {31'b0, ev2});
    chk("lat2_rdata", r2, ed2);
    chk("lat2_err", {31'b0, er2}, {31'b0, ee2});
    @(posedge clk);
    if (rst_n) begin
      ev2 = ev1; ed2 = ed1; ee2 = ee1;
      ev1 = t.v;
      ed1 = t.v ? t.exp : 32'h0;
      ee1 = t.v && t.err;
    end
    #1;
    cur_idx++;
  endtask

  initial begin
    #1;
    chk("reset_lat1_valid", {31'b0, v1}, 32'h0);
    chk("reset_lat1_rdata", r1, 32'h0);
    chk("reset_lat1_err", {31'b0, er1}, 32'h0);
    chk("reset_lat2_valid", {31'b0, v2}, 32'h0);
    chk("reset_lat2_rdata", r2, 32'h0);
    chk("reset_lat2_err", {31'b0, er2}, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    //           we    size uns addr          wdata         expected      err
    vecs.push_back(mk(1'b1, SW, 1'b0, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0));
    vecs.push_back(mk(1'b0, SW, 1'b0, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0));
    vecs.push_back(mk(1'b1, SW, 1'b0, 32'h10,   32'h11223344, 32'h0,        1'b0));
    vecs.push_back(mk(1'b1, SB, 1'b0, 32'h13,   32'hABCDEF80, 32'h0,        1'b0));
    vecs.push_back(mk(1'b0, SB, 1'b0, 32'h13,   32'h0,        32'hFFFFFF80, 1'b0));
    vecs.push_back(mk(1'b0, SB, 1'b1, 32'h13,   32'h0,        32'h00000080, 1'b0));
    vecs.push_back(mk(1'b0, SW, 1'b0, 32'h10,   32'h0,        32'h80223344, 1'b0));
    vecs.push_back(mk(1'b0, SB, 1'b0, 32'h10,   32'h0,        32'h00000044, 1'b0));
    vecs.push_back(mk(1'b0, SB, 1'b0, 32'h11,   32'h0,        32'h00000033, 1'b0));
    vecs.push_back(mk(1'b0, SB, 1'b1, 32'h12,   32'h0,        32'h00000022, 1'b0));
    vecs.push_back(idle());
    vecs.push_back(mk(1'b1, SH, 1'b0, 32'h12,   32'h1234A5A5, 32'h0,        1'b0));
    vecs.push_back(mk(1'b0, SH, 1'b0, 32'h12,   32'h0,        32'hFFFFA5A5, 1'b0));
    vecs.push_back(mk(1'b0, SH, 1'b1, 32'h12,   32'h0,        32'h0000A5A5, 1'b0));
    vecs.push_back(mk(1'b0, SW, 1'b0, 32'h10,   32'h0,        32'hA5A53344, 1'b0));
    vecs.push_back(mk(1'b0, SH, 1'b0, 32'h10,   32'h0,        32'h00003344, 1'b0));
    vecs.push_back(mk(1'b0, SW, 1'b1, 32'h10,   32'h0,        32'hA5A53344, 1'b0));
    vecs.push_back(mk(1'b0, SW, 1'b0, 32'h11,   32'h0,        32'h0,        1'b1));
    vecs.push_back(mk(1'b1, SH, 1'b0, 32'h13,   32'hFFFFFFFF, 32'h0,        1'b1));
    vecs.push_back(mk(1'b0, SR, 1'b0, 32'h10,   32'h0,        32'h0,        1'b1));
    vecs.push_back(mk(1'b1, SR, 1'b0, 32'h10,   32'h0,        32'h0,        1'b1));
    vecs.push_back(mk(1'b0, SW, 1'b0, 32'h1000, 32'h0,        32'h0,        1'b1));
    vecs.push_back(mk(1'b1, SW, 1'b0, 32'h1010, 32'h0,        32'h0,        1'b1));
    vecs.push_back(mk(1'b1, SW, 1'b0, 32'h12,   32'h0,        32'h0,        1'b1));
    vecs.push_back(mk(1'b0, SB, 1'b0, 32'h1013, 32'h0,        32'h0,        1'b1));
    vecs.push_back(mk(1'b0, SW, 1'b0, 32'h10,   32'h0,        32'hA5A53344, 1'b0));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1'b1, SW, 1'b0, 32'(4*i), 32'hC0DE0000 | 32'(i), 32'h0, 1'b0));
    vecs.push_back(mk(1'b1, SW, 1'b0, 32'h20, 32'h20202020, 32'h0, 1'b0));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1'b0, SW, 1'b0, 32'(4*i), 32'h0, 32'hC0DE0000 | 32'(i), 1'b0));
    vecs.push_back(idle());
    vecs.push_back(idle());
    vecs.push_back(idle());

    foreach (vecs[i]) step(vecs[i]);

    // Reset with two loads in flight, plus a store presented while reset is held.
    step(mk(1'b0, SW, 1'b0, 32'h00, 32'h0, 32'hC0DE0000, 1'b0));
    step(mk(1'b0, SW, 1'b0, 32'h04, 32'h0, 32'hC0DE0001, 1'b0));
    req_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("inflight_lat1_valid", {31'b0, v1}, 32'h0);
    chk("inflight_lat1_rdata", r1, 32'h0);
    chk("inflight_lat2_valid", {31'b0, v2}, 32'h0);
    chk("inflight_lat2_rdata", r2, 32'h0);
    ev1 = 1'b0; ev2 = 1'b0; ed1 = '0; ed2 = '0; ee1 = 1'b0; ee2 = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_size = SW;
    req_addr = 32'h20; req_wdata = 32'hBAD0BAD0;
    @(posedge clk);
    @(posedge clk);
    #1 req_valid = 1'b0;
    #2 rst_n = 1'b1;
    step(idle());
    step(idle());
    step(idle());
    step(mk(1'b0, SW, 1'b0, 32'h00, 32'h0, 32'hC0DE0000, 1'b0));
    step(mk(1'b0, SW, 1'b0, 32'h04, 32'h0, 32'hC0DE0001, 1'b0));
    step(mk(1'b0, SW, 1'b0, 32'h20, 32'h0, 32'h20202020, 1'b0));
    step(mk(1'b0, SB, 1'b0, 32'h1C, 32'h0, 32'h00000007, 1'b0));
    step(idle());
    step(idle());
    step(idle());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_mem_bytes.md
Name: data_mem_bytes

Overview:
- Parametrised, byte-addressed data memory for the SimpleCPU memory stage. It generalises the word-only single-port store.
- Supports byte, halfword and word loads and stores through per-byte write enables, with sign or zero extension on loads.
- Read latency is configurable: one pipeline stage, or two with an output register.
- Every request returns a response, and misaligned or out-of-range accesses are flagged instead of silently corrupting storage.

Parameters:
- DEPTH_LOG2, 10: memory holds 2^DEPTH_LOG2 32-bit words (byte range 0 .. 4*2^DEPTH_LOG2-1).
- READ_LATENCY, 1: cycles from request acceptance to rsp_valid. Legal values are 1 and 2; any other value is an elaboration error.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present this cycle; one request accepted per cycle, no backpressure
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend; ignored for stores and word loads
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- rsp_valid  out  1  response strobe, exactly READ_LATENCY cycles after an accepted request
- rsp_rdata  out  32  load result, right-aligned and extended; 0 for stores and errors
- rsp_err  out  1  request was misaligned, out of range or reserved size; qualified by rsp_valid

Behaviour:

Address decode:
- word index = req_addr[DEPTH_LOG2+1:2]
- byte lane = req_addr[1:0]

Error detection (combinational on the request):
- Out of range: any bit of req_addr[31:DEPTH_LOG2+2] is set.
- Misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
- Reserved: req_size=11.
- Any error suppresses the memory write.

Stores:
- Byte-enable mask: byte = 1<<lane; half = 0011 or 1100 according to addr[1]; word = 1111.
- The write data is replicated across lanes (byte ×4, half ×2), and only the enabled bytes of the word are written on the accept edge.
- No read-modify-write cycle is used.

Loads:
- The word is read synchronously on the accept edge.
- Stage 1 registers the read word, lane, size, unsigned flag, error and we.
- The lane is then selected and extended.
  - Byte: bits [8*lane+7 : 8*lane].
  - Half: bits [15:0] or [31:16].
  - Sign extension copies the selected MSB into all upper bits.

Latency and outputs:
- READ_LATENCY=1: extension logic drives rsp_* combinationally from the stage-1 registers; rsp_valid is the registered req_valid.
- READ_LATENCY=2: a second register stage holds the extended result, error and valid.
- Back-to-back requests every cycle are fully pipelined, giving one response per cycle in request order.

Read-after-write ordering:
- A load accepted the cycle after a store to the same word returns the stored data, because the write commits on the earlier edge.
- A single request cannot both read and write, so no same-cycle conflict exists.

Reset:
- rst_n=0 asynchronously clears rsp_valid, rsp_rdata and rsp_err to 0, along with all pipeline registers.
- Memory contents are not reset.
- A request in flight when reset asserts is dropped and no response is produced. A store whose accept edge occurs while rst_n=0 is not performed.

Store responses: rsp_valid=1, rsp_rdata=0, rsp_err as detected.

Idle cycles: when rsp_valid=0, rsp_rdata and rsp_err hold 0.

Test Plan:
1. Word store 0xDEADBEEF to addr 0x10, then word load 0x10 on the next cycle -> rsp_valid after READ_LATENCY, rsp_rdata=0xDEADBEEF, rsp_err=0.
2. Byte store 0x80 to 0x13 over word 0x11223344 at 0x10, then signed byte load 0x13 -> 0xFFFFFF80, unsigned -> 0x00000080, word load 0x10 -> 0x80223344.
3. Half store 0xA5A5 to 0x12, then signed half load 0x12 -> 0xFFFFA5A5, word at 0x10 -> 0xA5A5xxxx with the low half unchanged.
4. Word load at 0x11, half store at 0x13, req_size=11, and addr=4<<DEPTH_LOG2 -> rsp_err=1, rsp_rdata=0, target memory word unchanged on read-back.
5. Eight loads on consecutive cycles to 0x00..0x1C (pre-written) at READ_LATENCY=1 and 2 -> eight contiguous rsp_valid pulses, data in order.
6. Assert rst_n=0 mid-stream with two loads in flight -> rsp_valid falls to 0 immediately, no stale response after release; memory contents survive reset on read-back.
